// File: rtl/zet_prefetch_pkg.sv
// Shared constants and state encoding for the instruction prefetch queue.
package zet_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } pf_state_e;

  localparam int          QDEPTH       = 8;
  localparam logic [3:0]  REFILL_MAX   = 4'd6;
  localparam logic [19:0] RST_ADDR_DEF = 20'hFFFF0;

endpackage

// File: rtl/zet_prefetch_if.sv
// Word-wide read bus between the prefetch queue and memory.
interface zet_prefetch_if;
  logic [18:0] mem_adr;
  logic        mem_stb;
  logic        mem_ack;
  logic [15:0] mem_dat;

  modport master (output mem_adr, output mem_stb, input mem_ack, input mem_dat);
  modport slave  (input mem_adr, input mem_stb, output mem_ack, output mem_dat);
endinterface

// File: rtl/zet_prefetch_ram.sv
// 8x8 byte store: two write ports for a fetched word, two read ports at head/head+1.
module zet_prefetch_ram
  import zet_prefetch_pkg::*;
(
  input  logic       clk,
  input  logic       we0_i,
  input  logic [2:0] wa0_i,
  input  logic [7:0] wd0_i,
  input  logic       we1_i,
  input  logic [2:0] wa1_i,
  input  logic [7:0] wd1_i,
  input  logic [2:0] ra0_i,
  input  logic [2:0] ra1_i,
  output logic [7:0] rd0_o,
  output logic [7:0] rd1_o
);

  // Contents are deliberately not reset; readers gate on the queue count.
  logic [7:0] mem_q [QDEPTH];

  always_ff @(posedge clk) begin
    if (we0_i) mem_q[wa0_i] <= wd0_i;
    if (we1_i) mem_q[wa1_i] <= wd1_i;
  end

  assign rd0_o = mem_q[ra0_i];
  assign rd1_o = mem_q[ra1_i];

endmodule

// File: rtl/zet_prefetch.sv
// Instruction prefetch queue: keeps up to 8 bytes ahead of the fetch stage.
module zet_prefetch
  import zet_prefetch_pkg::*;
#(
  parameter logic [19:0] RST_ADDR = RST_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] pc,
  input  logic        flush,
  input  logic        consume,
  input  logic        bytefetch,
  output logic [15:0] data,
  output logic        block,
  zet_prefetch_if.master mem
);

  pf_state_e   state_q, state_d;
  logic [19:0] fa_q, fa_d;
  logic [18:0] adr_q, adr_d;
  logic [2:0]  head_q, head_d;
  logic [2:0]  tail_q, tail_d;
  logic [3:0]  count_q, count_d;

  logic       valid;
  logic       ack_wr;
  logic       odd;
  logic [2:0] take;
  logic [2:0] put;
  logic [7:0] wd0;
  logic [7:0] rd0, rd1;

  always_comb begin
    valid  = count_q >= (bytefetch ? 4'd1 : 4'd2);
    take   = (consume && valid) ? (bytefetch ? 3'd1 : 3'd2) : 3'd0;
    ack_wr = (state_q == REQ) && mem.mem_ack && !flush;
    odd    = fa_q[0];
    put    = ack_wr ? (odd ? 3'd1 : 3'd2) : 3'd0;
    // An odd fetch address only wants the upper byte of the returned word.
    wd0    = odd ? mem.mem_dat[15:8] : mem.mem_dat[7:0];
  end

  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    adr_d   = adr_q;
    head_d  = head_q + take;
    tail_d  = tail_q + put;
    count_d = count_q + {1'b0, put} - {1'b0, take};
    case (state_q)
      IDLE: begin
        if (!flush && count_q <= REFILL_MAX) begin
          state_d = REQ;
          adr_d   = fa_q[19:1];
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          state_d = IDLE;
          if (!flush) fa_d = fa_q + (odd ? 20'd1 : 20'd2);
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over consume and the ack write; adr_q stays put so the bus stays stable.
    if (flush) begin
      fa_d    = pc;
      head_d  = 3'd0;
      tail_d  = 3'd0;
      count_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fa_q    <= RST_ADDR;
      adr_q   <= RST_ADDR[19:1];
      head_q  <= 3'd0;
      tail_q  <= 3'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      adr_q   <= adr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  zet_prefetch_ram u_ram (
    .clk   (clk),
    .we0_i (ack_wr),
    .wa0_i (tail_q),
    .wd0_i (wd0),
    .we1_i (ack_wr && !odd),
    .wa1_i (tail_q + 3'd1),
    .wd1_i (mem.mem_dat[15:8]),
    .ra0_i (head_q),
    .ra1_i (head_q + 3'd1),
    .rd0_o (rd0),
    .rd1_o (rd1)
  );

  assign data        = {rd1, rd0};
  assign block       = ~valid;
  assign mem.mem_stb = (state_q != IDLE);
  assign mem.mem_adr = adr_q;

endmodule

// File: tb/tb_zet_prefetch.sv
// Randomized bench for zet_prefetch against a byte-queue reference model.
module tb_zet_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] pc;
  logic        flush, consume, bytefetch;
  logic [15:0] data;
  logic        block;

  zet_prefetch_if mem();

  zet_prefetch dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .flush     (flush),
    .consume   (consume),
    .bytefetch (bytefetch),
    .data      (data),
    .block     (block),
    .mem       (mem)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [18:0] a);
    logic [31:0] h;
    h = {13'd0, a} * 32'h9E3779B1 + 32'h1234567;
    return h[31:16];
  endfunction

  function automatic logic [7:0] byte_at(input logic [19:0] a);
    logic [15:0] w;
    w = word_at(a[19:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  assign mem.mem_dat = word_at(mem.mem_adr);

  int total  = 0;
  int passed = 0;

  // Reference model: a byte FIFO plus the outstanding request, if any.
  logic [7:0]  q[$];
  logic [19:0] m_fa;
  logic [18:0] m_adr;
  bit          m_busy, m_drop;
  int          wcnt;
  int          dmin, dmax;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_fa   = 20'hFFFF0;
    m_adr  = 19'd0;
    m_busy = 0;
    m_drop = 0;
    wcnt   = 0;
  endtask

  task automatic compare(input bit b);
    bit mv;
    mv = q.size() >= (b ? 1 : 2);
    chk("stb", {31'd0, mem.mem_stb}, {31'd0, m_busy});
    if (m_busy) chk("adr", {13'd0, mem.mem_adr}, {13'd0, m_adr});
    chk("block", {31'd0, block}, {31'd0, !mv});
    if (q.size() >= 2)      chk("data", {16'd0, data}, {16'd0, q[1], q[0]});
    else if (q.size() == 1) chk("data_lo", {24'd0, data[7:0]}, {24'd0, q[0]});
  endtask

  task automatic step(input bit f, input logic [19:0] p, input bit c, input bit b, input bit ack);
    int sz;
    bit mv;
    sz = q.size();
    mv = sz >= (b ? 1 : 2);
    if (f) begin
      q.delete();
      if (m_busy && !ack) begin
        m_drop = 1;
        wcnt--;
      end else if (m_busy) begin
        m_busy = 0;
        m_drop = 0;
      end
      m_fa = p;
    end else begin
      if (c && mv) begin
        void'(q.pop_front());
        if (!b) void'(q.pop_front());
      end
      if (m_busy) begin
        if (ack) begin
          if (!m_drop) begin
            q.push_back(byte_at(m_fa));
            if (m_fa[0]) m_fa = m_fa + 20'd1;
            else begin
              q.push_back(byte_at(m_fa + 20'd1));
              m_fa = m_fa + 20'd2;
            end
          end
          m_busy = 0;
          m_drop = 0;
        end else wcnt--;
      end else if (sz <= 6) begin
        m_busy = 1;
        m_adr  = m_fa[19:1];
        wcnt   = $urandom_range(dmax, dmin);
      end
    end
  endtask

  // One clock: drive away from the edge, check, advance the model, land after the next negedge.
  task automatic tick(input bit f, input logic [19:0] p, input bit c, input bit b);
    bit ack;
    ack         = m_busy && (wcnt == 0);
    flush       = f;
    pc          = p;
    consume     = c;
    bytefetch   = b;
    mem.mem_ack = ack;
    #1;
    compare(b);
    step(f, p, c, b, ack);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; pc = 20'd0; flush = 1'b0; consume = 1'b0; bytefetch = 1'b1;
    mem.mem_ack = 1'b0;
    dmin = 0; dmax = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stb", {31'd0, mem.mem_stb}, 32'd0);
    chk("rst_block", {31'd0, block}, 32'd1);
    rst = 1'b1;

    // Fill from reset with zero-wait memory
    tick(0, 20'd0, 0, 0);
    chk("first_stb", {31'd0, mem.mem_stb}, 32'd1);
    chk("first_adr", {13'd0, mem.mem_adr}, 32'h7FFF8);
    repeat (11) tick(0, 20'd0, 0, 0);
    chk("fill_count", q.size(), 32'd8);
    chk("fill_stb", {31'd0, mem.mem_stb}, 32'd0);
    chk("fill_block", {31'd0, block}, 32'd0);
    chk("fill_data", {16'd0, data}, {16'd0, word_at(19'h7FFF8)});

    // Odd flush target, blocked 2-byte consume with concurrent ack
    tick(1, 20'h00103, 0, 0);
    chk("odd_idle", {31'd0, mem.mem_stb}, 32'd0);
    tick(0, 20'd0, 0, 0);
    chk("odd_adr", {13'd0, mem.mem_adr}, 32'h00081);
    tick(0, 20'd0, 0, 0);
    tick(0, 20'd0, 1, 0);
    chk("odd_adr2", {13'd0, mem.mem_adr}, 32'h00082);
    chk("odd_cnt", q.size(), 32'd1);
    tick(0, 20'd0, 1, 0);
    chk("odd_cnt3", q.size(), 32'd3);
    chk("odd_valid", {31'd0, block}, 32'd0);
    chk("odd_data", {16'd0, data}, {16'd0, byte_at(20'h00104), byte_at(20'h00103)});
    chk("odd_fa", {12'd0, m_fa}, 32'h00106);

    // Flush while a slow request is outstanding
    dmin = 3; dmax = 3;
    tick(1, 20'h12340, 0, 1);
    tick(0, 20'd0, 0, 1);
    tick(0, 20'd0, 0, 1);
    tick(1, 20'h0ABC0, 0, 1);
    tick(0, 20'd0, 0, 1);
    tick(0, 20'd0, 0, 1);
    chk("disc_block", {31'd0, block}, 32'd1);
    chk("disc_stb", {31'd0, mem.mem_stb}, 32'd0);
    tick(0, 20'd0, 0, 1);
    chk("disc_stb2", {31'd0, mem.mem_stb}, 32'd1);
    chk("disc_adr", {13'd0, mem.mem_adr}, 32'h055E0);
    dmin = 0; dmax = 0;
    repeat (6) tick(0, 20'd0, 0, 1);

    // Address wrap at the top of the 1 MB space
    tick(1, 20'hFFFFE, 0, 0);
    tick(0, 20'd0, 0, 0);
    chk("wrap_adr", {13'd0, mem.mem_adr}, 32'h7FFFF);
    tick(0, 20'd0, 0, 0);
    tick(0, 20'd0, 0, 0);
    chk("wrap_adr0", {13'd0, mem.mem_adr}, 32'h00000);
    tick(0, 20'd0, 0, 0);
    chk("wrap_data", {16'd0, data}, {16'd0, byte_at(20'hFFFFF), byte_at(20'hFFFFE)});
    tick(0, 20'd0, 1, 0);
    chk("wrap_data2", {16'd0, data}, {16'd0, byte_at(20'h00001), byte_at(20'h00000)});

    // Random traffic with varying consume pressure and memory latency
    dmin = 0; dmax = 3;
    for (int i = 0; i < 3000; i++) begin
      int cb;
      cb = (i / 500) % 4;
      tick($urandom_range(15) == 0, 20'($urandom), $urandom_range(3) < cb, 1'($urandom_range(1)));
    end

    // Reset in the middle of a request drops stb without waiting for a clock
    dmin = 3; dmax = 3;
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 12 && !hit; i++) begin
        tick(0, 20'd0, 0, 1);
        if (m_busy && wcnt > 0) hit = 1;
      end
      chk("mid_req_found", {31'd0, hit}, 32'd1);
      chk("mid_stb", {31'd0, mem.mem_stb}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_stb", {31'd0, mem.mem_stb}, 32'd0);
      chk("async_block", {31'd0, block}, 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/zet_prefetch.md
ZET_PREFETCH -- requirements
Module: zet_prefetch

Interface
REQ-001 SHALL have parameter RST_ADDR, default 20'hFFFF0, meaning the fetch address loaded at reset (F000:FFF0).
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports are named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 pc  input  20  linear byte address of the instruction stream head; sampled only on flush.
REQ-006 flush  input  1  discards queue contents and restarts fetching at pc.
REQ-007 consume  input  1  fetch stage takes bytes this cycle.
REQ-008 bytefetch  input  1  1 = consume takes 1 byte; 0 = consume takes 2 bytes.
REQ-009 data  output  16  {queue[head+1], queue[head]}; high byte is don't-care when count<2.
REQ-010 block  output  1  ~valid; valid = count >= (bytefetch ? 1 : 2).
REQ-011 mem_adr  output  19  word address (fetch address bits [19:1]).
REQ-012 mem_stb  output  1  read request; held high until mem_ack.
REQ-013 mem_ack  input  1  read completes this cycle; mem_dat is valid.
REQ-014 mem_dat  input  16  little-endian word read from memory.

Function
REQ-015 Queue SHALL be 8 bytes: circular storage, 3-bit head/tail pointers wrapping mod 8, 4-bit count 0..8.
REQ-016 States: IDLE (no request), REQ (stb high, data wanted), DISCARD (stb high, data to be dropped).
REQ-017 IDLE->REQ when count <= 6 and no flush; mem_stb asserts in the following cycle, with mem_adr = fa[19:1].
REQ-018 On ack in REQ: if fa[0]=0, write both bytes (low byte first) and fa += 2; if fa[0]=1, write the high byte only and fa += 1; return to IDLE.
REQ-019 fa SHALL wrap modulo 2^20; a word fetch at 20'hFFFFE followed by the next fetch at 20'h00000 is legal.
REQ-020 Ack data SHALL become visible on data/valid in the cycle after ack; there is no bypass.
REQ-021 A consume is honoured only when valid=1; it advances head by 1 or 2 and decrements count by the same amount.
REQ-022 Ack write and consume in the same cycle: count = count + written - consumed; the pointers update independently.
REQ-023 On flush: count, head and tail go to 0, and fa <= pc. From REQ without ack, the next state is DISCARD. From REQ with ack, or from IDLE, the next state is IDLE, and the ack data is dropped.
REQ-024 DISCARD keeps mem_stb and mem_adr stable until ack, drops the data, then goes to IDLE.
REQ-025 Flush has priority over consume and over the ack write in the same cycle.
REQ-026 A flush while in DISCARD SHALL reload fa and remain in DISCARD.
REQ-027 mem_adr SHALL NOT change while mem_stb is high.

Reset
REQ-028 On rst low: state IDLE, mem_stb 0, count 0, head 0, tail 0, fa RST_ADDR, block 1.
REQ-029 Storage contents SHALL NOT be reset; data is don't-care until the first valid.
REQ-030 A reset asserted mid-request SHALL drop mem_stb immediately (asynchronous); no DISCARD is needed.

Structure
REQ-031 The state encodings (IDLE=2'd0, REQ=2'd1, DISCARD=2'd2), queue depth 8, refill threshold 6 and RST_ADDR SHALL live in the shared defines include.
REQ-032 The byte storage (8x8, two write ports per word, two read ports at head and head+1) SHALL be a sub-module zet_prefetch_ram; control and pointers stay in zet_prefetch.

Verification
REQ-033 Reset release, zero-wait memory -> first mem_adr 19'h7FFF8, queue fills to 8, block=0 with data=word at FFFF0.
REQ-034 flush with pc=20'h00103 -> mem_adr 19'h00081, 1 byte stored, next mem_adr 19'h00082, fa=00106.
REQ-035 flush while stb is pending with ack delayed 3 cycles -> DISCARD; that ack's data is never visible; the next request uses the new pc.
REQ-036 count=1, bytefetch=0, consume=1 -> block=1, head and count unchanged; an ack the same cycle brings count to 3, valid next cycle.
REQ-037 Consume of 2 bytes concurrent with an even-address ack at count=6 -> count stays 6; data shows the next two bytes in order.
REQ-038 fa=20'hFFFFE -> mem_adr 19'h7FFFF, then 19'h00000; byte order in the queue is preserved across the wrap.
